// File: rtl/xbar_cfg_loader_if.sv
// Configuration write port for xbar_cfg_loader: valid/ready handshake
// carrying an output index and the input select to load for it.
interface xbar_cfg_loader_if #(
    parameter int ADDR_W = 6,
    parameter int SEL_W  = 5
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [SEL_W-1:0]  cfg_sel;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_sel,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_sel,
        output cfg_ready
    );
endinterface

// File: rtl/xbar_cfg_loader.sv
// xbar_cfg_loader: shadow/active configuration controller for the LUT-tile
// input crossbar. Select writes land in a shadow image; a commit copies the
// whole image into the active packed mux-config vector in a single edge.
// Also provides a sequenced field-by-field clear, a sticky range error and a
// commit epoch counter.
// Optional feature: define XBAR_CFG_READBACK_EN to add a registered shadow
// readback port (rd_addr / rd_sel / rd_err).
module xbar_cfg_loader #(
    parameter int NUM_INS  = 27,
    parameter int NUM_OUTS = 35,
    parameter int SEL_W    = 5,
    parameter int ADDR_W   = 6,
    parameter int EPOCH_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    xbar_cfg_loader_if.slave           cfg,
    input  logic                       commit,
    input  logic                       clear,
    output logic                       busy,
    output logic                       commit_done,
    output logic                       err,
    output logic [EPOCH_W-1:0]         cfg_epoch,
    output logic [NUM_OUTS*SEL_W-1:0]  io_mux_configs
`ifdef XBAR_CFG_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [SEL_W-1:0]           rd_sel,
    output logic                       rd_err
`endif
);

    localparam int IMG_W = NUM_OUTS * SEL_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [IMG_W-1:0]    shadow_q, shadow_d;
    logic [IMG_W-1:0]    active_q, active_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [EPOCH_W-1:0]  epoch_q,  epoch_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;
    logic                ready_s;
    logic                wr_ok_s;

    // A write is legal only when both the output index and the select fit.
    assign wr_ok_s = (32'(cfg.cfg_addr) < NUM_OUTS) && (32'(cfg.cfg_sel) < NUM_INS);

    assign cfg.cfg_ready  = ready_s;
    assign busy           = (state_q != ST_IDLE);
    assign commit_done    = done_q;
    assign err            = err_q;
    assign cfg_epoch      = epoch_q;
    assign io_mux_configs = active_q;

    // State register and all datapath registers; reset aborts any clear/commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            active_q  <= '0;
            clr_cnt_q <= '0;
            epoch_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            clr_cnt_q <= clr_cnt_d;
            epoch_q   <= epoch_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath updates; priority in IDLE is clear > commit > write.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        clr_cnt_d = clr_cnt_q;
        epoch_d   = epoch_q;
        done_d    = 1'b0;
        err_d     = err_q;
        ready_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_s = !clear && !commit;
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    err_d     = 1'b0;
                end else if (commit) begin
                    state_d = ST_COMMIT;
                end else if (cfg.cfg_valid) begin
                    if (wr_ok_s) begin
                        for (int i = 0; i < NUM_OUTS; i++) begin
                            shadow_d[i*SEL_W +: SEL_W] = (cfg.cfg_addr == ADDR_W'(i))
                                ? cfg.cfg_sel : shadow_q[i*SEL_W +: SEL_W];
                        end
                    end else begin
                        // Illegal write is still consumed; only the flag records it.
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                for (int i = 0; i < NUM_OUTS; i++) begin
                    shadow_d[i*SEL_W +: SEL_W] = (clr_cnt_q == ADDR_W'(i))
                        ? {SEL_W{1'b0}} : shadow_q[i*SEL_W +: SEL_W];
                end
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_COMMIT: begin
                active_d = shadow_q;
                epoch_d  = epoch_q + EPOCH_W'(1);
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef XBAR_CFG_READBACK_EN
    logic [SEL_W-1:0] rd_sel_q, rd_sel_d;
    logic             rd_err_q, rd_err_d;

    assign rd_sel = rd_sel_q;
    assign rd_err = rd_err_q;

    // Select the addressed shadow field; out-of-range addresses read as zero.
    always_comb begin
        rd_sel_d = '0;
        rd_err_d = 1'b0;
        if (32'(rd_addr) < NUM_OUTS) begin
            for (int i = 0; i < NUM_OUTS; i++) begin
                rd_sel_d = (rd_addr == ADDR_W'(i)) ? shadow_q[i*SEL_W +: SEL_W] : rd_sel_d;
            end
        end else begin
            rd_err_d = 1'b1;
        end
    end

    // Readback result register, one cycle after rd_addr is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_sel_q <= '0;
            rd_err_q <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel_d;
            rd_err_q <= rd_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Self-checking bench for xbar_cfg_loader: directed scenarios plus random
// write/commit traffic compared against an array-based model of the shadow
// and active images, epoch count and sticky error.
module tb_xbar_cfg_loader;

    localparam int NI = 27;
    localparam int NO = 35;
    localparam int SW = 5;
    localparam int AW = 6;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic reset;
    logic commit;
    logic clear;
    logic busy;
    logic commit_done;
    logic err;
    logic [EW-1:0] cfg_epoch;
    logic [NO*SW-1:0] io_mux_configs;
`ifdef XBAR_CFG_READBACK_EN
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_sel;
    logic          rd_err;
`endif

    xbar_cfg_loader_if #(.ADDR_W(AW), .SEL_W(SW)) cfg_if ();

    xbar_cfg_loader #(
        .NUM_INS(NI), .NUM_OUTS(NO), .SEL_W(SW), .ADDR_W(AW), .EPOCH_W(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg(cfg_if),
        .commit(commit),
        .clear(clear),
        .busy(busy),
        .commit_done(commit_done),
        .err(err),
        .cfg_epoch(cfg_epoch),
        .io_mux_configs(io_mux_configs)
`ifdef XBAR_CFG_READBACK_EN
        ,
        .rd_addr(rd_addr),
        .rd_sel(rd_sel),
        .rd_err(rd_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model
    int m_shadow [NO];
    int m_active [NO];
    int m_epoch;
    bit m_err;

    int vectors = 0;
    int errors  = 0;

    function automatic logic [NO*SW-1:0] pack_img(input int img [NO]);
        logic [NO*SW-1:0] v;
        v = '0;
        for (int i = 0; i < NO; i++) v[i*SW +: SW] = SW'(img[i]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NO; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_epoch = 0;
        m_err   = 1'b0;
    endtask

    task automatic do_write(input int addr, input int sel);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = AW'(addr);
        cfg_if.cfg_sel   = SW'(sel);
        #1;
        chk("wr_ready", 256'(cfg_if.cfg_ready), 256'(1));
        tick();
        cfg_if.cfg_valid = 1'b0;
        if (addr < NO && sel < NI) m_shadow[addr] = sel;
        else m_err = 1'b1;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("commit_busy", 256'(busy), 256'(1));
        chk("commit_done_early", 256'(commit_done), 256'(0));
        tick();
        m_active = m_shadow;
        m_epoch  = (m_epoch + 1) % 256;
        chk("commit_img", 256'(io_mux_configs), 256'(pack_img(m_active)));
        chk("commit_done", 256'(commit_done), 256'(1));
        chk("commit_epoch", 256'(cfg_epoch), 256'(m_epoch));
        tick();
        chk("commit_done_pulse", 256'(commit_done), 256'(0));
    endtask

    // Counts busy cycles after CLEAR has been entered; stray writes are driven.
    task automatic run_clear(input string tag);
        int n;
        logic [NO*SW-1:0] img_before;
        img_before = pack_img(m_active);
        n = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = AW'(3);
        cfg_if.cfg_sel   = SW'(5);
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            if (cfg_if.cfg_ready !== 1'b0 || commit_done !== 1'b0 ||
                io_mux_configs !== img_before) begin
                chk({tag, "_in_clear"}, 256'({cfg_if.cfg_ready, commit_done}), 256'(0));
                chk({tag, "_img_hold"}, 256'(io_mux_configs), 256'(img_before));
            end
            n++;
            tick();
        end
        cfg_if.cfg_valid = 1'b0;
        chk({tag, "_busy_cycles"}, 256'(n), 256'(NO));
        for (int i = 0; i < NO; i++) m_shadow[i] = 0;
        m_err = 1'b0;
        chk({tag, "_err_cleared"}, 256'(err), 256'(0));
    endtask

    initial begin
        int done_cnt;
        int r;
        reset = 1'b0;
        commit = 1'b0;
        clear = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_sel   = '0;
`ifdef XBAR_CFG_READBACK_EN
        rd_addr = '0;
`endif
        model_reset();
        tick(); tick();
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(commit_done), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_epoch", 256'(cfg_epoch), 256'(0));
        chk("rst_img", 256'(io_mux_configs), 256'(0));
        reset = 1'b1;
        tick();

        // Basic write + commit
        do_write(0, 26);
        do_write(34, 3);
        do_commit();
        chk("t1_field0", 256'(io_mux_configs[4:0]), 256'(26));
        chk("t1_field34", 256'(io_mux_configs[174:170]), 256'(3));
        chk("t1_epoch", 256'(cfg_epoch), 256'(1));

        // Illegal writes set err and leave the shadow alone
        do_write(5, 27);
        do_write(35, 1);
        chk("t2_err", 256'(err), 256'(1));
        do_commit();
        chk("t2_field5", 256'(io_mux_configs[29:25]), 256'(0));
        chk("t2_err_sticky", 256'(err), 256'(m_err));

        // All fields 7, commit, clear, commit again
        for (int i = 0; i < NO; i++) do_write(i, 7);
        do_commit();
        chk("t3_all7", 256'(io_mux_configs), 256'({NO{5'd7}}));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        run_clear("t3");
        chk("t3_still7", 256'(io_mux_configs), 256'({NO{5'd7}}));
        do_commit();
        chk("t3_all0", 256'(io_mux_configs), 256'(0));

        // clear, commit and write together: clear wins, write refused
        do_write(9, 4);
        clear = 1'b1;
        commit = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = AW'(2);
        cfg_if.cfg_sel   = SW'(11);
        #1;
        chk("t4_ready", 256'(cfg_if.cfg_ready), 256'(0));
        tick();
        clear = 1'b0;
        commit = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        chk("t4_busy", 256'(busy), 256'(1));
        run_clear("t4");
        chk("t4_no_commit", 256'(cfg_epoch), 256'(m_epoch));
        do_commit();

        // Random traffic against the model
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            if (r < 7) do_write($urandom_range(0, 40), $urandom_range(0, 31));
            else if (r < 9) do_commit();
            else chk("rnd_err", 256'(err), 256'(m_err));
        end
        do_commit();
        chk("rnd_err_end", 256'(err), 256'(m_err));

`ifdef XBAR_CFG_READBACK_EN
        do_write(12, 9);
        rd_addr = AW'(12);
        tick();
        chk("rb_sel", 256'(rd_sel), 256'(9));
        chk("rb_err0", 256'(rd_err), 256'(0));
        rd_addr = AW'(40);
        tick();
        chk("rb_oor_sel", 256'(rd_sel), 256'(0));
        chk("rb_oor_err", 256'(rd_err), 256'(1));
        rd_addr = '0;
`endif

        // Reset during clear aborts immediately
        do_write(1, 13);
        do_commit();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("t5_busy_pre", 256'(busy), 256'(1));
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t5_busy", 256'(busy), 256'(0));
        chk("t5_done", 256'(commit_done), 256'(0));
        chk("t5_err", 256'(err), 256'(0));
        chk("t5_epoch", 256'(cfg_epoch), 256'(0));
        chk("t5_img", 256'(io_mux_configs), 256'(0));
        tick();
        reset = 1'b1;
        tick();

        // Commit held high: one commit per two cycles, epoch wraps
        done_cnt = 0;
        commit = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            tick();
            if (commit_done === 1'b1) begin
                done_cnt++;
                m_epoch = (m_epoch + 1) % 256;
            end
            if (k == 510) chk("t6_epoch255", 256'(cfg_epoch), 256'(255));
        end
        commit = 1'b0;
        chk("t6_count", 256'(done_cnt), 256'(256));
        chk("t6_wrap", 256'(cfg_epoch), 256'(0));
        chk("t6_model", 256'(cfg_epoch), 256'(m_epoch));
        tick();
        chk("t6_idle", 256'(busy), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
